mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Lets instruction fetch (IF) and the data path (loads/stores) share one
// single-port memory bus. A request is captured in IDLE, driven onto mem_* until
// mem_ack (or until the wait timeout expires), and the response is handed back
// to the requester that owns the transaction. Data requests win over fetch.
// A pipeline flush cancels an outstanding fetch: the bus cycle still runs to
// completion (DRAIN), but no response reaches the fetch side.
//
// Optional feature: define ARB_STARVE_EN to stop fetch from starving. After
// STARVE_LIMIT consecutive lost arbitrations, fetch wins the next one even
// if dm_req is high. Without the macro, data always wins.
//
// Ports
//   clk, reset                     clock (rising edge), synchronous active-high reset
//   if_req / if_addr               fetch request (level, sampled in IDLE)
//   if_gnt / if_done / if_rdata    fetch accept pulse, completion pulse, read data
//   dm_req / dm_we / dm_addr       data request, store flag, address
//   dm_wdata / dm_wstrb            store data and byte enables
//   dm_gnt / dm_done / dm_rdata    data accept pulse, completion pulse, load data
//   bus_err                        completion was a timeout abort (with *_done)
//   flush_in                       pipeline flush, cancels fetch
//   mem_req/we/addr/wdata/wstrb    memory bus request, held stable until ack
//   mem_ack / mem_rdata            memory completion and read data (same cycle)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_done,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_gnt,
    output logic                dm_done,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                bus_err,
    input  logic                flush_in,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    if (TIMEOUT < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("mem_port_arbiter: TIMEOUT and STARVE_LIMIT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, DATA, FETCH, DRAIN} state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic [STRB_W-1:0]   mem_wstrb_nxt;
    logic                if_gnt_nxt, dm_gnt_nxt, if_done_nxt, dm_done_nxt, bus_err_nxt;
    logic [DATA_W-1:0]   if_rdata_nxt, dm_rdata_nxt;
    logic                starve_force;
    logic                fetch_win;
    logic                timeout_hit;

`ifdef ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_cnt, starve_nxt;

    assign starve_force = (starve_cnt == STARVE_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (reset) starve_cnt <= '0;
        else       starve_cnt <= starve_nxt;
    end
`else
    assign starve_force = 1'b0;
`endif

    // Flush in IDLE suppresses only the fetch grant; data may still win.
    assign fetch_win   = if_req && !flush_in && (!dm_req || starve_force);
    // This wait cycle would bring wait_cnt up to TIMEOUT.
    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        wait_nxt      = wait_cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        mem_wstrb_nxt = mem_wstrb;
        if_gnt_nxt    = 1'b0;
        dm_gnt_nxt    = 1'b0;
        if_done_nxt   = 1'b0;
        dm_done_nxt   = 1'b0;
        bus_err_nxt   = 1'b0;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
`ifdef ARB_STARVE_EN
        starve_nxt    = starve_cnt;
`endif

        case (state)
            IDLE: begin
                // A late mem_ack seen here is deliberately ignored.
                if (fetch_win) begin
                    state_nxt     = FETCH;
                    if_gnt_nxt    = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    mem_wdata_nxt = '0;
                    mem_wstrb_nxt = '0;
                    wait_nxt      = '0;
`ifdef ARB_STARVE_EN
                    starve_nxt    = '0;
`endif
                end else if (dm_req) begin
                    state_nxt     = DATA;
                    dm_gnt_nxt    = 1'b1;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    mem_wstrb_nxt = dm_we ? dm_wstrb : '0;
                    wait_nxt      = '0;
`ifdef ARB_STARVE_EN
                    if (if_req && !starve_force)
                        starve_nxt = starve_cnt + 1'b1;
`endif
                end
            end

            default: begin  // DATA, FETCH, DRAIN: bus cycle in flight
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                    if (state == DATA) begin
                        dm_done_nxt  = 1'b1;
                        dm_rdata_nxt = mem_rdata;
                    end else if (state == FETCH && !flush_in) begin
                        if_done_nxt  = 1'b1;
                        if_rdata_nxt = mem_rdata;
                    end
                end else if (timeout_hit) begin
                    // Abort: owner gets an error completion, read data untouched.
                    mem_req_nxt = 1'b0;
                    state_nxt   = IDLE;
                    wait_nxt    = WAIT_W'(TIMEOUT);
                    if (state == DATA) begin
                        dm_done_nxt = 1'b1;
                        bus_err_nxt = 1'b1;
                    end else if (state == FETCH && !flush_in) begin
                        if_done_nxt = 1'b1;
                        bus_err_nxt = 1'b1;
                    end
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                    if (state == FETCH && flush_in)
                        state_nxt = DRAIN;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            bus_err   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_wstrb <= mem_wstrb_nxt;
            if_gnt    <= if_gnt_nxt;
            dm_gnt    <= dm_gnt_nxt;
            if_done   <= if_done_nxt;
            dm_done   <= dm_done_nxt;
            bus_err   <= bus_err_nxt;
            if_rdata  <= if_rdata_nxt;
            dm_rdata  <= dm_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Scoreboard bench for mem_port_arbiter. Stimulus pushes the expected grant
// (owner + bus contents) and expected completion (owner + data + error) into
// queues; a monitor on the falling edge pops and compares whenever the DUT
// pulses a grant or a done. A small memory responder acks after a programmable
// delay and returns data derived from the address.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_done;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_gnt, dm_done;
    logic [31:0] dm_rdata;
    logic        bus_err;
    logic        flush_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_wstrb (dm_wstrb),
        .dm_gnt   (dm_gnt),
        .dm_done  (dm_done),
        .dm_rdata (dm_rdata),
        .bus_err  (bus_err),
        .flush_in (flush_in),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_dm;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } gnt_t;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        bit          err;
    } done_t;

    gnt_t  exp_gnt[$];
    done_t exp_done[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_gnt(input bit is_dm, input logic [31:0] addr, input bit we,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        gnt_t g;
        g.is_dm = is_dm; g.addr = addr; g.we = we; g.wdata = wdata; g.wstrb = wstrb;
        exp_gnt.push_back(g);
    endtask

    task automatic push_done(input bit is_dm, input logic [31:0] rdata, input bit err);
        done_t d;
        d.is_dm = is_dm; d.rdata = rdata; d.err = err;
        exp_done.push_back(d);
    endtask

    // ---------------- memory responder ----------------
    bit ack_en    = 1'b1;
    int ack_delay = 1;
    bit force_ack = 1'b0;
    int age       = 0;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'hC0DE_0000);
    endfunction

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (mem_req === 1'b1) begin
                mem_ack = (ack_en && age == ack_delay) || force_ack;
                age++;
            end else begin
                mem_ack = force_ack;
                age     = 0;
            end
            mem_rdata = rdata_for(mem_addr);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic  prev_mem_req = 1'b0;
    gnt_t  mg;
    done_t md;

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (if_gnt || dm_gnt) begin
                check("gnt_both", if_gnt & dm_gnt, 0);
                check("gnt_bus_idle_before", prev_mem_req, 0);
                check("gnt_expected", exp_gnt.size() != 0, 1);
                if (exp_gnt.size() != 0) begin
                    mg = exp_gnt.pop_front();
                    check("gnt_owner_dm", dm_gnt, mg.is_dm);
                    check("mem_req_at_gnt", mem_req, 1);
                    check("mem_addr", mem_addr, mg.addr);
                    check("mem_we", mem_we, mg.we);
                    check("mem_wstrb", mem_wstrb, mg.wstrb);
                    if (mg.we) check("mem_wdata", mem_wdata, mg.wdata);
                end
            end
            if (if_done || dm_done) begin
                check("done_both", if_done & dm_done, 0);
                check("done_expected", exp_done.size() != 0, 1);
                if (exp_done.size() != 0) begin
                    md = exp_done.pop_front();
                    check("done_owner_dm", dm_done, md.is_dm);
                    check("done_rdata", md.is_dm ? dm_rdata : if_rdata, md.rdata);
                    check("done_bus_err", bus_err, md.err);
                end
            end else if (bus_err) begin
                check("bus_err_without_done", bus_err, 0);
            end
        end
        prev_mem_req = mem_req;
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_gnt(input int who);  // 0 = fetch, 1 = data, 2 = either
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            if ((who == 0 && if_gnt) || (who == 1 && dm_gnt) || (who == 2 && (if_gnt || dm_gnt)))
                seen = 1'b1;
        end
        check("gnt_wait_bound", seen, 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk); #1;
            if (if_done || dm_done) seen = 1'b1;
        end
        check("done_wait_bound", seen, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {if_gnt, if_done, dm_gnt, dm_done, bus_err, mem_req, mem_we}, 0);
        check({tag, "_rdata"}, {if_rdata, dm_rdata}, 0);
        check({tag, "_mem_bus"}, {mem_addr, mem_wdata}, 0);
        check({tag, "_wstrb"}, mem_wstrb, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        int  req_cycles;
        bit  done_seen;

        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = '0;
        flush_in = 1'b0;
        cycles(3);
        check_all_zero("reset_init");
        reset = 1'b0;

        // 1: load 0x100, ack two cycles after mem_req rises
        ack_delay = 2;
        push_gnt(1'b1, 32'h100, 1'b0, 32'h0, 4'h0);
        push_done(1'b1, 32'hDEAD_BEEF, 1'b0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        wait_gnt(1);
        dm_req = 1'b0;
        wait_done();
        cycles(2);

        // 2: simultaneous requests, data first then fetch
        ack_delay = 1;
        push_gnt(1'b1, 32'h200, 1'b0, 32'h0, 4'h0);
        push_done(1'b1, 32'hC0DE_0200, 1'b0);
        push_gnt(1'b0, 32'h40, 1'b0, 32'h0, 4'h0);
        push_done(1'b0, 32'hC0DE_0040, 1'b0);
        dm_req = 1'b1; dm_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h40;
        wait_gnt(1);
        dm_req = 1'b0;
        wait_gnt(0);
        if_req = 1'b0;
        wait_done();
        cycles(2);

        // 3: fetch flushed one cycle after grant, ack three cycles after mem_req
        ack_delay = 3;
        push_gnt(1'b0, 32'h40, 1'b0, 32'h0, 4'h0);
        if_req = 1'b1; if_addr = 32'h40;
        wait_gnt(0);
        if_req = 1'b0;
        cycles(1);
        flush_in = 1'b1;
        cycles(1);
        flush_in = 1'b0;
        check("drain_holds_mem_req", mem_req, 1);
        cycles(5);
        check("drain_released_mem_req", mem_req, 0);
        check("drain_if_rdata_held", if_rdata, 32'hC0DE_0040);
        // flush in IDLE must block the fetch grant (no grant is queued here)
        ack_delay = 1;
        if_req = 1'b1; if_addr = 32'h80; flush_in = 1'b1;
        cycles(3);
        push_gnt(1'b0, 32'h80, 1'b0, 32'h0, 4'h0);
        push_done(1'b0, 32'hC0DE_0080, 1'b0);
        flush_in = 1'b0;
        wait_gnt(0);
        if_req = 1'b0;
        wait_done();
        cycles(2);

        // 4: store with ack withheld -> timeout abort after 15 wait cycles
        ack_en = 1'b0;
        push_gnt(1'b1, 32'h300, 1'b1, 32'h1234, 4'h3);
        push_done(1'b1, 32'hC0DE_0200, 1'b1);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h300; dm_wdata = 32'h1234; dm_wstrb = 4'h3;
        wait_gnt(1);
        dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0; dm_wstrb = '0;
        req_cycles = mem_req ? 1 : 0;
        done_seen  = 1'b0;
        for (int i = 0; i < 40 && !done_seen; i++) begin
            @(posedge clk); #1;
            if (dm_done) done_seen = 1'b1;
            else if (mem_req) req_cycles++;
        end
        check("timeout_done_seen", done_seen, 1);
        check("timeout_req_cycles", req_cycles, 15);
        check("timeout_mem_req_low", mem_req, 0);
        ack_en = 1'b1;
        cycles(2);

        // 5: reset in the middle of a transaction, then a stray ack
        ack_en = 1'b0;
        push_gnt(1'b1, 32'h400, 1'b0, 32'h0, 4'h0);
        dm_req = 1'b1; dm_addr = 32'h400;
        wait_gnt(1);
        dm_req = 1'b0;
        cycles(2);
        check("pre_reset_mem_req", mem_req, 1);
        reset = 1'b1;
        cycles(1);
        check_all_zero("reset_mid");
        reset = 1'b0;
        force_ack = 1'b1;
        cycles(1);
        force_ack = 1'b0;
        cycles(3);
        check("stray_ack_mem_req", mem_req, 0);
        ack_en = 1'b1;
        ack_delay = 1;
        push_gnt(1'b1, 32'h600, 1'b0, 32'h0, 4'h0);
        push_done(1'b1, 32'hC0DE_0600, 1'b0);
        dm_req = 1'b1; dm_addr = 32'h600;
        wait_gnt(1);
        dm_req = 1'b0;
        wait_done();
        cycles(2);

        // 6: continuous data requests competing with fetch
        ack_delay = 0;
`ifdef ARB_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            push_gnt(1'b1, 32'h500, 1'b0, 32'h0, 4'h0);
            push_done(1'b1, 32'hC0DE_0500, 1'b0);
        end
`else
        for (int i = 0; i < 5; i++) begin
            push_gnt(1'b1, 32'h500, 1'b0, 32'h0, 4'h0);
            push_done(1'b1, 32'hC0DE_0500, 1'b0);
        end
`endif
        push_gnt(1'b0, 32'h44, 1'b0, 32'h0, 4'h0);
        push_done(1'b0, 32'hC0DE_0044, 1'b0);
        dm_req = 1'b1; dm_addr = 32'h500;
        if_req = 1'b1; if_addr = 32'h44;
        for (int i = 0; i < 5; i++) wait_gnt(2);
        dm_req = 1'b0;
`ifndef ARB_STARVE_EN
        wait_gnt(0);
`endif
        if_req = 1'b0;
        wait_done();
        cycles(5);

        check("gnt_queue_drained", exp_gnt.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
